// File: rtl/forwarding_unit.sv
// -----------------------------------------------------------------------------
// forwarding_unit
//
// Purpose:
//   Control side of the EX-stage operand forwarding muxes. A shadow copy of the
//   register tags held in the EX, MEM and WB pipeline latches is kept here and
//   used to drive the operand-select lines of the EX muxes:
//     2'b00 = ID read data, 2'b01 = MEM-stage data, 2'b10 = WB-stage data.
//   Load-use hazards raise a single stall cycle. During that cycle a bubble
//   enters the shadow EX slot, mirroring the bubble loaded into ID/EX.
//
// Ports:
//   i_clock        system clock, rising edge
//   i_reset        synchronous, active-high reset (priority over all inputs)
//   i_valid_id     ID holds a valid instruction advancing to EX
//   i_rs_id        source register A of the ID instruction
//   i_rt_id        source register B of the ID instruction
//   i_rd_id        destination register of the ID instruction
//   i_regwrite_id  ID instruction writes the register file
//   i_memread_id   ID instruction is a load
//   i_flush        kill the instruction entering EX (taken branch/jump)
//   o_fwd_a        select for the EX operand A mux
//   o_fwd_b        select for the EX operand B mux
//   o_stall        hold PC and IF/ID; ID/EX loads a bubble
//   o_stall_count  saturating count of stall cycles
// -----------------------------------------------------------------------------
module forwarding_unit #(
    parameter int NB_REG = 5,
    parameter int NB_SEL = 2,
    parameter int NB_CNT = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_valid_id,
    input  logic [NB_REG-1:0] i_rs_id,
    input  logic [NB_REG-1:0] i_rt_id,
    input  logic [NB_REG-1:0] i_rd_id,
    input  logic              i_regwrite_id,
    input  logic              i_memread_id,
    input  logic              i_flush,
    output logic [NB_SEL-1:0] o_fwd_a,
    output logic [NB_SEL-1:0] o_fwd_b,
    output logic              o_stall,
    output logic [NB_CNT-1:0] o_stall_count
);

    localparam logic [NB_SEL-1:0] SEL_ID  = NB_SEL'(2'b00);
    localparam logic [NB_SEL-1:0] SEL_MEM = NB_SEL'(2'b01);
    localparam logic [NB_SEL-1:0] SEL_WB  = NB_SEL'(2'b10);
    localparam logic [NB_REG-1:0] REG_ZERO = {NB_REG{1'b0}};
    localparam logic [NB_CNT-1:0] CNT_MAX  = {NB_CNT{1'b1}};

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_STALLED = 1'b1
    } stall_state_t;

    // Shadow EX slot
    logic              ex_valid_r;
    logic [NB_REG-1:0] ex_rs_r;
    logic [NB_REG-1:0] ex_rt_r;
    logic [NB_REG-1:0] ex_rd_r;
    logic              ex_regwrite_r;
    logic              ex_memread_r;

    // Shadow MEM slot
    logic              mem_valid_r;
    logic [NB_REG-1:0] mem_rd_r;
    logic              mem_regwrite_r;

    // Shadow WB slot
    logic              wb_valid_r;
    logic [NB_REG-1:0] wb_rd_r;
    logic              wb_regwrite_r;

    stall_state_t      state_r;
    stall_state_t      state_next_s;
    logic [NB_CNT-1:0] stall_count_r;

    logic              hazard_s;
    logic              stall_s;
    logic              ex_load_s;
    logic [NB_SEL-1:0] fwd_a_s;
    logic [NB_SEL-1:0] fwd_b_s;

    // A later stage can supply register r only if it really writes a non-zero r.
    function automatic logic stage_hit(
        input logic              valid,
        input logic              regwrite,
        input logic [NB_REG-1:0] rd,
        input logic [NB_REG-1:0] r
    );
        return valid & regwrite & (rd != REG_ZERO) & (rd == r);
    endfunction

    // MEM holds the younger result, so it wins over WB for the same register.
    function automatic logic [NB_SEL-1:0] pick_source(
        input logic              ex_valid,
        input logic              mem_hit,
        input logic              wb_hit
    );
        logic [NB_SEL-1:0] sel;
        sel = SEL_ID;
        if (!ex_valid) begin
            sel = SEL_ID;
        end else if (mem_hit) begin
            sel = SEL_MEM;
        end else if (wb_hit) begin
            sel = SEL_WB;
        end else begin
            sel = SEL_ID;
        end
        return sel;
    endfunction

    // Load in EX whose destination is a source of the instruction now in ID.
    always_comb begin
        hazard_s = i_valid_id & ex_valid_r & ex_memread_r & ex_regwrite_r &
                   (ex_rd_r != REG_ZERO) &
                   ((ex_rd_r == i_rs_id) | (ex_rd_r == i_rt_id));
    end

    // Stall only from RUN, so one load-use pair yields exactly one stall cycle.
    always_comb begin
        stall_s      = 1'b0;
        state_next_s = ST_RUN;
        case (state_r)
            ST_RUN: begin
                stall_s      = hazard_s;
                state_next_s = hazard_s ? ST_STALLED : ST_RUN;
            end
            ST_STALLED: begin
                stall_s      = 1'b0;
                state_next_s = ST_RUN;
            end
            default: begin
                stall_s      = 1'b0;
                state_next_s = ST_RUN;
            end
        endcase
    end

    // Decide whether the ID instruction enters the shadow EX slot or a bubble does.
    always_comb begin
        ex_load_s = i_valid_id & ~i_flush & ~stall_s;
    end

    // Operand selects, derived only from registered shadow state.
    always_comb begin
        fwd_a_s = pick_source(ex_valid_r,
                              stage_hit(mem_valid_r, mem_regwrite_r, mem_rd_r, ex_rs_r),
                              stage_hit(wb_valid_r, wb_regwrite_r, wb_rd_r, ex_rs_r));
        fwd_b_s = pick_source(ex_valid_r,
                              stage_hit(mem_valid_r, mem_regwrite_r, mem_rd_r, ex_rt_r),
                              stage_hit(wb_valid_r, wb_regwrite_r, wb_rd_r, ex_rt_r));
    end

    // Shadow pipeline advance: WB <= MEM, MEM <= EX, EX <= ID or bubble.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            ex_valid_r     <= 1'b0;
            ex_rs_r        <= REG_ZERO;
            ex_rt_r        <= REG_ZERO;
            ex_rd_r        <= REG_ZERO;
            ex_regwrite_r  <= 1'b0;
            ex_memread_r   <= 1'b0;
            mem_valid_r    <= 1'b0;
            mem_rd_r       <= REG_ZERO;
            mem_regwrite_r <= 1'b0;
            wb_valid_r     <= 1'b0;
            wb_rd_r        <= REG_ZERO;
            wb_regwrite_r  <= 1'b0;
        end else begin
            wb_valid_r     <= mem_valid_r;
            wb_rd_r        <= mem_rd_r;
            wb_regwrite_r  <= mem_regwrite_r;
            mem_valid_r    <= ex_valid_r;
            mem_rd_r       <= ex_rd_r;
            mem_regwrite_r <= ex_regwrite_r;
            if (ex_load_s) begin
                ex_valid_r    <= 1'b1;
                ex_rs_r       <= i_rs_id;
                ex_rt_r       <= i_rt_id;
                ex_rd_r       <= i_rd_id;
                ex_regwrite_r <= i_regwrite_id;
                ex_memread_r  <= i_memread_id;
            end else begin
                ex_valid_r    <= 1'b0;
                ex_rs_r       <= REG_ZERO;
                ex_rt_r       <= REG_ZERO;
                ex_rd_r       <= REG_ZERO;
                ex_regwrite_r <= 1'b0;
                ex_memread_r  <= 1'b0;
            end
        end
    end

    // Stall FSM state register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Saturating stall-cycle counter; sticks at all-ones instead of wrapping.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            stall_count_r <= {NB_CNT{1'b0}};
        end else if (stall_s && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + NB_CNT'(1);
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign o_fwd_a       = fwd_a_s;
    assign o_fwd_b       = fwd_b_s;
    assign o_stall       = stall_s;
    assign o_stall_count = stall_count_r;

endmodule

// File: tb/tb_forwarding_unit.sv
// -----------------------------------------------------------------------------
// tb_forwarding_unit
//
// Directed-vector bench for forwarding_unit. Every expected value is written
// by hand from the pipeline timing; the stall counter is instantiated narrow
// so saturation is reachable in a few dozen cycles.
// -----------------------------------------------------------------------------
module tb_forwarding_unit;

    localparam int NB_REG = 5;
    localparam int NB_SEL = 2;
    localparam int NB_CNT = 4;
    localparam int CNT_MAX = (1 << NB_CNT) - 1;

    logic              clk;
    logic              rst;
    logic              valid_id;
    logic [NB_REG-1:0] rs_id;
    logic [NB_REG-1:0] rt_id;
    logic [NB_REG-1:0] rd_id;
    logic              regwrite_id;
    logic              memread_id;
    logic              flush;
    logic [NB_SEL-1:0] fwd_a;
    logic [NB_SEL-1:0] fwd_b;
    logic              stall;
    logic [NB_CNT-1:0] stall_count;

    int checks_r = 0;
    int errors_r = 0;
    int exp_cnt  = 0;

    forwarding_unit #(
        .NB_REG (NB_REG),
        .NB_SEL (NB_SEL),
        .NB_CNT (NB_CNT)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_valid_id    (valid_id),
        .i_rs_id       (rs_id),
        .i_rt_id       (rt_id),
        .i_rd_id       (rd_id),
        .i_regwrite_id (regwrite_id),
        .i_memread_id  (memread_id),
        .i_flush       (flush),
        .o_fwd_a       (fwd_a),
        .o_fwd_b       (fwd_b),
        .o_stall       (stall),
        .o_stall_count (stall_count)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_r++;
        if (act !== exp) begin
            errors_r++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [NB_REG-1:0] rs, input logic [NB_REG-1:0] rt,
                         input logic [NB_REG-1:0] rd, input logic rw, input logic mr);
        valid_id    = v;
        rs_id       = rs;
        rt_id       = rt;
        rd_id       = rd;
        regwrite_id = rw;
        memread_id  = mr;
    endtask

    // Present an instruction in ID and clock it into EX.
    task automatic issue(input logic v, input logic [NB_REG-1:0] rs, input logic [NB_REG-1:0] rt,
                         input logic [NB_REG-1:0] rd, input logic rw, input logic mr);
        drive(v, rs, rt, rd, rw, mr);
        tick();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        end
    endtask

    task automatic bump_cnt();
        if (exp_cnt < CNT_MAX) exp_cnt++;
    endtask

    // lw rX followed by a consumer of rX: one stall cycle, counter +1.
    task automatic load_use_pair(input logic [NB_REG-1:0] r);
        issue(1'b1, 5'd2, 5'd0, r, 1'b1, 1'b1);
        drive(1'b1, r, 5'd1, 5'd9, 1'b1, 1'b0);
        #1;
        check_eq("sat_pair_stall", 32'(stall), 32'd1);
        tick();
        bump_cnt();
        idle(1);
    endtask

    initial begin
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        flush = 1'b0;
        rst   = 1'b1;

        // Reset held two cycles with random ID-side inputs.
        for (int k = 0; k < 2; k++) begin
            drive(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                  1'($urandom), 1'($urandom));
            flush = 1'($urandom);
            tick();
        end
        check_eq("rst_fwd_a", 32'(fwd_a), 32'd0);
        check_eq("rst_fwd_b", 32'(fwd_b), 32'd0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_count", 32'(stall_count), 32'd0);

        rst   = 1'b0;
        flush = 1'b0;
        idle(1);
        check_eq("post_rst_fwd_a", 32'(fwd_a), 32'd0);
        check_eq("post_rst_fwd_b", 32'(fwd_b), 32'd0);
        check_eq("post_rst_stall", 32'(stall), 32'd0);

        // add r3<-r1,r2 ; sub r5<-r3,r4 : MEM forward on A only.
        issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        issue(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0);
        check_eq("exex_fwd_a", 32'(fwd_a), 32'd1);
        check_eq("exex_fwd_b", 32'(fwd_b), 32'd0);
        idle(1);
        check_eq("bubble_fwd_a", 32'(fwd_a), 32'd0);
        idle(2);

        // Two writers of r3, consumer reads r3 twice: MEM wins over WB.
        issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        issue(1'b1, 5'd4, 5'd5, 5'd3, 1'b1, 1'b0);
        issue(1'b1, 5'd3, 5'd3, 5'd6, 1'b1, 1'b0);
        check_eq("prio_fwd_a", 32'(fwd_a), 32'd1);
        check_eq("prio_fwd_b", 32'(fwd_b), 32'd1);
        idle(2);

        // Writer of r3, writer of r10, consumer rs=r3 (WB) rt=r10 (MEM).
        issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        issue(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b0);
        issue(1'b1, 5'd3, 5'd10, 5'd12, 1'b1, 1'b0);
        check_eq("wb_fwd_a", 32'(fwd_a), 32'd2);
        check_eq("mem_fwd_b", 32'(fwd_b), 32'd1);
        idle(3);

        // lw r7 ; add r8<-r7,r1 held in ID across the stall.
        issue(1'b1, 5'd2, 5'd0, 5'd7, 1'b1, 1'b1);
        drive(1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0);
        #1;
        check_eq("lu_stall", 32'(stall), 32'd1);
        tick();
        bump_cnt();
        check_eq("lu_stall_once", 32'(stall), 32'd0);
        check_eq("lu_bubble_fwd_a", 32'(fwd_a), 32'd0);
        check_eq("lu_count", 32'(stall_count), 32'(exp_cnt));
        tick();
        check_eq("lu_consumer_fwd_a", 32'(fwd_a), 32'd2);
        check_eq("lu_consumer_fwd_b", 32'(fwd_b), 32'd0);
        check_eq("lu_consumer_stall", 32'(stall), 32'd0);
        idle(3);

        // Writer of r0 then reader of r0: never forwarded.
        issue(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
        issue(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
        check_eq("r0_fwd_a", 32'(fwd_a), 32'd0);
        check_eq("r0_fwd_b", 32'(fwd_b), 32'd0);
        idle(3);

        // Flushed producer of r3: later readers see no source.
        flush = 1'b1;
        issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        flush = 1'b0;
        issue(1'b1, 5'd3, 5'd3, 5'd9, 1'b1, 1'b0);
        check_eq("flush_mem_fwd_a", 32'(fwd_a), 32'd0);
        issue(1'b1, 5'd3, 5'd3, 5'd11, 1'b1, 1'b0);
        check_eq("flush_wb_fwd_b", 32'(fwd_b), 32'd0);
        idle(3);

        // lw r0 then reader of r0: no stall.
        issue(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b1);
        drive(1'b1, 5'd0, 5'd5, 5'd6, 1'b1, 1'b0);
        #1;
        check_eq("lw_r0_stall", 32'(stall), 32'd0);
        idle(3);

        // Flush coinciding with a load-use stall: still stalls and counts.
        issue(1'b1, 5'd2, 5'd0, 5'd7, 1'b1, 1'b1);
        drive(1'b1, 5'd1, 5'd7, 5'd8, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        check_eq("flush_stall", 32'(stall), 32'd1);
        tick();
        bump_cnt();
        flush = 1'b0;
        check_eq("flush_stall_count", 32'(stall_count), 32'(exp_cnt));
        check_eq("flush_stall_bubble_b", 32'(fwd_b), 32'd0);
        idle(3);

        // Drive the narrow counter past its maximum.
        for (int p = 0; p < CNT_MAX + 2; p++) begin
            load_use_pair(5'd7);
        end
        check_eq("sat_count", 32'(stall_count), 32'(CNT_MAX));
        load_use_pair(5'd12);
        check_eq("sat_hold", 32'(stall_count), 32'(CNT_MAX));
        idle(2);

        // Reset asserted while STALLED.
        issue(1'b1, 5'd2, 5'd0, 5'd7, 1'b1, 1'b1);
        drive(1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        check_eq("midstall_rst_stall", 32'(stall), 32'd0);
        check_eq("midstall_rst_count", 32'(stall_count), 32'd0);
        check_eq("midstall_rst_fwd_a", 32'(fwd_a), 32'd0);
        rst = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
        $finish;
    end

endmodule
